// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared state type, constants and helpers for the median line controller
package median_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam int DEF_PIC_WIDTH = 320;
  localparam int OUT_PER_LINE  = DEF_PIC_WIDTH - 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port read-before-write line RAM with registered read
module line_buffer
  import median_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 320,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // read data holds between accesses so taps can be replayed
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/median_line_ctrl.sv
// rtl/median_line_ctrl.sv - line-buffered tap sequencer and output re-timer for the 3x3 median core
module median_line_ctrl
  import median_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 320,
  parameter int PIC_HEIGHT = 240,
  parameter int MED_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sof,
  output logic             mf_valid,
  output logic [WIDTH-1:0] mf_din1,
  output logic [WIDTH-1:0] mf_din2,
  output logic [WIDTH-1:0] mf_din3,
  input  logic [WIDTH-1:0] mf_dout,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             frame_done,
  output logic             err_sof
);

  localparam int COL_W  = clog2(PIC_WIDTH);
  localparam int ROW_W  = clog2(PIC_HEIGHT);
  localparam int BEAT_W = clog2(PIC_WIDTH + MED_LAT + 1);
  localparam int LAT_W  = clog2(MED_LAT + 1);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(PIC_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(PIC_HEIGHT - 1);
  localparam logic [BEAT_W-1:0] BEAT_FIRST = BEAT_W'(2 + MED_LAT);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(PIC_WIDTH + MED_LAT - 1);
  localparam logic [LAT_W-1:0]  FLUSH_LAST = LAT_W'(MED_LAT - 1);

  state_t            r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [BEAT_W-1:0] r_beat;
  logic [LAT_W-1:0]  r_flush_cnt;
  logic              r_wr_sel;
  logic              r_tap_sel;
  logic              r_line_first;
  logic              r_line_last;
  logic              r_mf_valid;
  logic [WIDTH-1:0]  r_din3;
  logic              r_cap0, r_sof0, r_eol0, r_fd0;
  logic              r_cap1, r_sof1, r_eol1, r_fd1;
  logic              r_m_valid, r_m_sof, r_m_eol, r_fd2;
  logic [WIDTH-1:0]  r_m_data;
  logic              r_frame_done;
  logic              r_err_sof;

  logic              w_xfer, w_active, w_restart, w_keep, w_issue, w_sel;
  logic [COL_W-1:0]  w_addr;
  logic [WIDTH-1:0]  w_a_q, w_b_q;

  assign s_ready   = (r_state != FLUSH);
  assign w_xfer    = s_valid && s_ready;
  assign w_active  = (r_state == FILL) || (r_state == RUN);
  assign w_restart = w_xfer && s_sof;
  assign w_keep    = w_xfer && ((r_state != IDLE) || s_sof);
  assign w_issue   = (r_state == RUN && w_xfer && !s_sof) || (r_state == FLUSH);
  assign w_addr    = w_restart ? '0 : r_col;
  assign w_sel     = w_restart ? 1'b0 : r_wr_sel;

  // Ping-pong rows: the buffer holding row r-2 is overwritten by row r, so it
  // becomes row r-1 for the next line without copying between buffers.
  line_buffer #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .ADDR_W(COL_W)) u_buf_a (
    .clk(clk), .rst(rst), .i_en(w_keep), .i_we(w_keep && !w_sel),
    .i_addr(w_addr), .i_wdata(s_data), .o_rdata(w_a_q)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .ADDR_W(COL_W)) u_buf_b (
    .clk(clk), .rst(rst), .i_en(w_keep), .i_we(w_keep && w_sel),
    .i_addr(w_addr), .i_wdata(s_data), .o_rdata(w_b_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_beat       <= '0;
      r_flush_cnt  <= '0;
      r_wr_sel     <= 1'b0;
      r_tap_sel    <= 1'b0;
      r_line_first <= 1'b0;
      r_line_last  <= 1'b0;
      r_mf_valid   <= 1'b0;
      r_din3       <= '0;
      {r_cap0, r_sof0, r_eol0, r_fd0} <= '0;
      {r_cap1, r_sof1, r_eol1, r_fd1} <= '0;
      {r_m_valid, r_m_sof, r_m_eol, r_fd2} <= '0;
      r_m_data     <= '0;
      r_frame_done <= 1'b0;
      r_err_sof    <= 1'b0;
    end else begin
      r_mf_valid <= 1'b0;
      r_err_sof  <= w_restart && w_active && ((r_row != '0) || (r_col != '0));
      if (w_keep) begin
        r_din3    <= s_data;
        r_tap_sel <= w_sel;
      end

      r_cap0 <= w_issue && (r_beat >= BEAT_FIRST) && (r_beat <= BEAT_LAST);
      r_sof0 <= w_issue && (r_beat == BEAT_FIRST) && r_line_first;
      r_eol0 <= w_issue && (r_beat == BEAT_LAST);
      r_fd0  <= w_issue && (r_beat == BEAT_LAST) && r_line_last;
      {r_cap1, r_sof1, r_eol1, r_fd1} <= {r_cap0, r_sof0, r_eol0, r_fd0};
      {r_m_valid, r_m_sof, r_m_eol, r_fd2} <= {r_cap1, r_sof1, r_eol1, r_fd1};
      if (r_cap1) r_m_data <= mf_dout;
      r_frame_done <= r_fd2;

      if (w_issue) begin
        r_mf_valid <= 1'b1;
        r_beat     <= r_beat + 1'b1;
        if (r_beat == '0) begin
          r_line_first <= (r_row == ROW_W'(2));
          r_line_last  <= (r_row == ROW_LAST);
        end
      end

      case (r_state)
        IDLE: begin
          if (w_restart) begin
            r_state  <= FILL;
            r_col    <= COL_W'(1);
            r_row    <= '0;
            r_beat   <= '0;
            r_wr_sel <= 1'b0;
          end
        end
        FILL, RUN: begin
          if (w_restart) begin
            r_state  <= FILL;
            r_col    <= COL_W'(1);
            r_row    <= '0;
            r_beat   <= '0;
            r_wr_sel <= 1'b0;
            // drop anything still in flight from the aborted line
            {r_cap1, r_sof1, r_eol1, r_fd1}       <= '0;
            {r_m_valid, r_m_sof, r_m_eol, r_fd2}  <= '0;
          end else if (w_xfer) begin
            if (r_col == COL_LAST) begin
              r_col    <= '0;
              r_row    <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
              r_wr_sel <= ~r_wr_sel;
              if (r_state == RUN) begin
                r_state     <= FLUSH;
                r_flush_cnt <= '0;
              end else if (r_row == ROW_W'(1)) begin
                r_state <= RUN;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            r_beat  <= '0;
            r_state <= r_line_last ? IDLE : RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mf_valid   = r_mf_valid;
  assign mf_din1    = r_tap_sel ? w_b_q : w_a_q;
  assign mf_din2    = r_tap_sel ? w_a_q : w_b_q;
  assign mf_din3    = r_din3;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_sof      = r_m_sof;
  assign m_eol      = r_m_eol;
  assign frame_done = r_frame_done;
  assign err_sof    = r_err_sof;

endmodule

// File: doc/median_line_ctrl.md
Name: median_line_ctrl

Overview:
Sequencer for the 3x3 median core (matrix_3x3).
- Accepts a raster pixel stream over a valid/ready handshake.
- Holds the previous two image lines in two line buffers and presents three vertically aligned taps (din1 oldest row, din3 current row) to the core with a qualifying strobe.
- Inserts flush beats at each line end to drain the core pipeline.
- Re-times the core output into a cropped stream with frame/line markers: (PIC_WIDTH-2) x (PIC_HEIGHT-2) pixels per frame.

Parameters:
- WIDTH, 24, pixel width (RGB888).
- PIC_WIDTH, 320, pixels per line; must be ≥ 4.
- PIC_HEIGHT, 240, lines per frame; must be ≥ 3.
- MED_LAT, 2, core beats between a window's completing beat and its median appearing on mf_dout (mf_dout is sampled the cycle after a beat).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  controller accepts pixel
- s_data  in  WIDTH  input pixel
- s_sof  in  1  first pixel of frame, qualified by s_valid
- mf_valid  out  1  beat strobe to core valid_in
- mf_din1  out  WIDTH  tap, row r-2
- mf_din2  out  WIDTH  tap, row r-1
- mf_din3  out  WIDTH  tap, row r
- mf_dout  in  WIDTH  core median result
- m_valid  out  1  output pixel valid, 1-cycle pulse
- m_data  out  WIDTH  filtered pixel
- m_sof  out  1  first output pixel of frame
- m_eol  out  1  last output pixel of line
- frame_done  out  1  1-cycle pulse after last output of frame
- err_sof  out  1  1-cycle pulse when s_sof arrives mid-frame

Behaviour:
- Interface: one clock domain clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0 except s_ready. Registers clear: col=0, row=0, beat=0, state=IDLE. Line buffer contents are don't-care.
- Handshake: a pixel transfers when s_valid && s_ready. s_ready=1 in IDLE, FILL and RUN; s_ready=0 in FLUSH.
- Line buffers: buf_a holds row r-1, buf_b holds row r-2. Each depth PIC_WIDTH, indexed by col, read-before-write in the same cycle. On a transfer: buf_b[col] <= buf_a[col]; buf_a[col] <= s_data.
- Taps are registered: mf_din3=s_data, mf_din2=buf_a[col], mf_din1=buf_b[col], all valid in the cycle mf_valid=1 (1 cycle after transfer).
- States:
  - IDLE: wait for a transfer with s_sof=1. That pixel is col 0 of row 0 -> FILL. Pixels without s_sof are accepted and dropped.
  - FILL: rows 0-1 written to buffers, mf_valid stays 0. At col==PIC_WIDTH-1 of row 1 -> RUN.
  - RUN: every transfer writes buffers and issues one mf_valid beat. At col==PIC_WIDTH-1 -> FLUSH.
  - FLUSH: issue MED_LAT beats on consecutive cycles, repeating the last taps. Then, if row==PIC_HEIGHT-1 -> IDLE, else -> RUN.
- Counters: col wraps PIC_WIDTH-1 -> 0 and increments row. row wraps to 0 at frame end. beat counts core beats per line, 0..PIC_WIDTH+MED_LAT-1, cleared on leaving FLUSH.
- Output capture: cycle after a beat with beat index b, where 2+MED_LAT ≤ b ≤ PIC_WIDTH+MED_LAT-1, set m_valid=1 and m_data=mf_dout. This gives exactly PIC_WIDTH-2 outputs per line.
  - m_sof: first output of row 2.
  - m_eol: output with b==PIC_WIDTH+MED_LAT-1.
  - frame_done: cycle after the m_eol of row PIC_HEIGHT-1.
- Early s_sof: s_sof on a transfer in FILL/RUN with (row,col)≠(0,0) pulses err_sof. That pixel becomes col 0 of row 0, state -> FILL, beat cleared. Outputs already scheduled from the aborted line are suppressed.
- Simultaneous events: the FLUSH last beat and an input s_valid do not transfer (s_ready=0). The pixel is taken the next cycle in RUN.
- Reset mid-frame: next cycle is IDLE with counters 0. The first s_sof restarts cleanly with no stale outputs.
- Widths: col is $clog2(PIC_WIDTH), row is $clog2(PIC_HEIGHT), beat is $clog2(PIC_WIDTH+MED_LAT+1). Counter arithmetic is unsigned with no saturation.

Decomposition:
- Package median_pkg: state enum {IDLE, FILL, RUN, FLUSH}; the function clog2; the constant OUT_PER_LINE = PIC_WIDTH-2.
- Sub-module line_buffer (parameters WIDTH, DEPTH): single-port read-before-write RAM with registered read. It is instantiated twice.

Test Plan:
- Use PIC_WIDTH=8, PIC_HEIGHT=5, MED_LAT=2 throughout, with a behavioural core model of latency 2.
- Basic frame: 40 pixels, value = row*8+col, s_sof on first, continuous s_valid -> 18 m_valid. m_sof on the first, m_eol every 6th. First m_data=9, which is the median of window rows0-2, cols0-2. frame_done once.
- FILL/FLUSH timing: s_valid continuous -> no mf_valid during rows 0-1. s_ready low exactly 2 cycles after each col 7 of rows 2-4. 10 beats per line.
- Gapped input: s_valid toggled 1010 -> same 18 outputs, identical data as the basic frame, and one mf_valid per accepted pixel.
- Early sof: s_sof asserted at row 3 col 4 -> err_sof pulse, no m_eol for the aborted line. The following 40 pixels give a complete 18-pixel frame.
- Reset mid-frame: rst for 1 cycle at row 2 col 3 -> no m_valid until row 2 of a new s_sof frame. Outputs then match the basic frame.
- Pre-sof garbage: 5 pixels without s_sof before a frame -> all accepted (s_ready=1), no mf_valid. The frame output is identical to the basic frame.
